redp_adc_capture: RTL and testbench



---
 rtl/redp_adc_capture.sv | 186 ++++++++++++++++++
 tb/tb_redp_adc_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/redp_adc_capture.sv
// Two-channel ADC capture: pad registration, offset-binary (negative slope) to
// two's complement conversion, enable/settle gating, 2^n averaging and sticky overrange.
module redp_adc_capture #(
  parameter int ADC_W         = 14,
  parameter int MAX_LOG2      = 10,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             adc_clk,
  input  logic             adc_rstn,
  input  logic             enable,
  input  logic [3:0]       dec_log2,
  input  logic             ovr_clr,
  input  logic [ADC_W-1:0] adc_dat_a_i,
  input  logic [ADC_W-1:0] adc_dat_b_i,
  output logic [ADC_W-1:0] dat_a_o,
  output logic [ADC_W-1:0] dat_b_o,
  output logic             valid_o,
  output logic             ovr_a_o,
  output logic             ovr_b_o,
  output logic             running_o
);

  localparam int ACC_W = ADC_W + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       EXP_MAX  = 4'(MAX_LOG2);
  localparam logic signed [ADC_W-1:0] FS_POS = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic signed [ADC_W-1:0] FS_NEG = {1'b1, {(ADC_W-1){1'b0}}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  function automatic logic signed [ADC_W-1:0] to_signed(input logic [ADC_W-1:0] raw);
    return {raw[ADC_W-1], ~raw[ADC_W-2:0]};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [ADC_W-1:0] s);
    return {{MAX_LOG2{s[ADC_W-1]}}, s};
  endfunction

  function automatic logic is_full_scale(input logic signed [ADC_W-1:0] s);
    return (s == FS_POS) || (s == FS_NEG);
  endfunction

  // Arithmetic shift floors toward minus infinity; the average always fits ADC_W.
  function automatic logic signed [ADC_W-1:0] floor_avg(input logic signed [ACC_W-1:0] sum,
                                                       input logic [3:0] sh);
    logic signed [ACC_W-1:0] t;
    t = sum >>> sh;
    return t[ADC_W-1:0];
  endfunction

  logic        [ADC_W-1:0] raw_a_p0_q, raw_b_p0_q;
  logic signed [ADC_W-1:0] s_a_p1_q, s_b_p1_q;

  logic [1:0]              state_q, state_d;
  logic [SET_W-1:0]        set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0]        smp_cnt_q, smp_cnt_d;
  logic [3:0]              dec_q;
  logic signed [ACC_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic signed [ACC_W-1:0] sum_a, sum_b;
  logic [ADC_W-1:0]        dat_a_q, dat_a_d, dat_b_q, dat_b_d;
  logic                    valid_q, valid_d;
  logic                    ovr_a_q, ovr_a_d, ovr_b_q, ovr_b_d;
  logic [3:0]              exp_eff;
  logic [CNT_W-1:0]        last_cnt;
  logic                    in_run;

  // Stage 0: pad capture
  always_ff @(posedge adc_clk) begin
    raw_a_p0_q <= adc_dat_a_i;
    raw_b_p0_q <= adc_dat_b_i;
  end

  // Stage 1: format conversion
  always_ff @(posedge adc_clk) begin
    s_a_p1_q <= to_signed(raw_a_p0_q);
    s_b_p1_q <= to_signed(raw_b_p0_q);
  end

  assign in_run   = (state_q == ST_RUN);
  assign exp_eff  = (dec_log2 > EXP_MAX) ? EXP_MAX : dec_log2;
  assign last_cnt = (CNT_ONE << exp_eff) - CNT_ONE;
  assign sum_a    = acc_a_q + sext(s_a_p1_q);
  assign sum_b    = acc_b_q + sext(s_b_p1_q);

  // Accumulate / decimate stage
  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    smp_cnt_d = smp_cnt_q;
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    dat_a_d   = dat_a_q;
    dat_b_d   = dat_b_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        acc_a_d   = '0;
        acc_b_d   = '0;
        smp_cnt_d = '0;
        set_cnt_d = '0;
        if (enable) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        acc_a_d   = '0;
        acc_b_d   = '0;
        smp_cnt_d = '0;
        if (!enable) begin
          state_d   = ST_IDLE;
          set_cnt_d = '0;
        end else if (set_cnt_q == SET_LAST) begin
          state_d   = ST_RUN;
          set_cnt_d = '0;
        end else begin
          set_cnt_d = set_cnt_q + SET_ONE;
        end
      end
      ST_RUN: begin
        if (!enable || (dec_log2 != dec_q)) begin
          // Leaving RUN or a new exponent: the partial block is dropped.
          if (!enable) state_d = ST_IDLE;
          acc_a_d   = '0;
          acc_b_d   = '0;
          smp_cnt_d = '0;
        end else if (smp_cnt_q == last_cnt) begin
          dat_a_d   = floor_avg(sum_a, exp_eff);
          dat_b_d   = floor_avg(sum_b, exp_eff);
          valid_d   = 1'b1;
          acc_a_d   = '0;
          acc_b_d   = '0;
          smp_cnt_d = '0;
        end else begin
          acc_a_d   = sum_a;
          acc_b_d   = sum_b;
          smp_cnt_d = smp_cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new overrange event takes priority over a simultaneous clear.
  assign ovr_a_d = (in_run && is_full_scale(s_a_p1_q)) ? 1'b1 : (ovr_clr ? 1'b0 : ovr_a_q);
  assign ovr_b_d = (in_run && is_full_scale(s_b_p1_q)) ? 1'b1 : (ovr_clr ? 1'b0 : ovr_b_q);

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q   <= ST_IDLE;
      set_cnt_q <= '0;
      smp_cnt_q <= '0;
      dec_q     <= '0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      dat_a_q   <= '0;
      dat_b_q   <= '0;
      valid_q   <= 1'b0;
      ovr_a_q   <= 1'b0;
      ovr_b_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      dec_q     <= dec_log2;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      dat_a_q   <= dat_a_d;
      dat_b_q   <= dat_b_d;
      valid_q   <= valid_d;
      ovr_a_q   <= ovr_a_d;
      ovr_b_q   <= ovr_b_d;
    end
  end

  assign dat_a_o   = dat_a_q;
  assign dat_b_o   = dat_b_q;
  assign valid_o   = valid_q;
  assign ovr_a_o   = ovr_a_q;
  assign ovr_b_o   = ovr_b_q;
  assign running_o = in_run;

endmodule

// File: tb/tb_redp_adc_capture.sv
// Bench for redp_adc_capture: directed steps plus random pads, compared each edge
// against a sample-stream reference model (queues of blocks, integer floor division).
module tb_redp_adc_capture;

  localparam int ADC_W    = 14;
  localparam int MAX_LOG2 = 10;
  localparam int SETTLE   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [3:0]       dec = 4'd0;
  logic [ADC_W-1:0] pad_a = 14'h2000;
  logic [ADC_W-1:0] pad_b = 14'h2000;
  logic [ADC_W-1:0] dat_a_o, dat_b_o;
  logic             valid_o, ovr_a_o, ovr_b_o, running_o;

  int checks = 0;
  int failures = 0;

  redp_adc_capture #(.ADC_W(ADC_W), .MAX_LOG2(MAX_LOG2), .SETTLE_CYCLES(SETTLE)) dut (
    .adc_clk(clk), .adc_rstn(rst_n), .enable(en), .dec_log2(dec), .ovr_clr(clr),
    .adc_dat_a_i(pad_a), .adc_dat_b_i(pad_b),
    .dat_a_o(dat_a_o), .dat_b_o(dat_b_o), .valid_o(valid_o),
    .ovr_a_o(ovr_a_o), .ovr_b_o(ovr_b_o), .running_o(running_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  int hist_a[$], hist_b[$];
  int blk_a[$], blk_b[$];
  int mphase, msettle, mdec_prev;
  logic [ADC_W-1:0] e_dat_a, e_dat_b;
  logic e_valid, e_ovr_a, e_ovr_b;

  function automatic int eff_exp(input int d);
    return (d > MAX_LOG2) ? MAX_LOG2 : d;
  endfunction

  function automatic int fdiv(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic bit full(input int s);
    return (s == 8191) || (s == -8192);
  endfunction

  // Negative-slope offset code: raw 0 is +full scale, each code step is -1.
  function automatic int conv(input int raw);
    return 8191 - raw;
  endfunction

  function automatic int raw_of(input int s);
    return 8191 - s;
  endfunction

  task automatic model_reset();
    mphase = 0; msettle = 0; mdec_prev = 0;
    blk_a.delete(); blk_b.delete();
    e_dat_a = '0; e_dat_b = '0; e_valid = 1'b0; e_ovr_a = 1'b0; e_ovr_b = 1'b0;
  endtask

  task automatic model_edge();
    int sa, sb, n, suma, sumb;
    sa = (hist_a.size() == 3) ? conv(hist_a[0]) : 0;
    sb = (hist_b.size() == 3) ? conv(hist_b[0]) : 0;
    e_ovr_a = (mphase == 2 && full(sa)) ? 1'b1 : (clr ? 1'b0 : e_ovr_a);
    e_ovr_b = (mphase == 2 && full(sb)) ? 1'b1 : (clr ? 1'b0 : e_ovr_b);
    e_valid = 1'b0;
    if (mphase == 0) begin
      blk_a.delete(); blk_b.delete();
      if (en) begin mphase = 1; msettle = 0; end
    end else if (mphase == 1) begin
      blk_a.delete(); blk_b.delete();
      if (!en) mphase = 0;
      else begin
        msettle++;
        if (msettle == SETTLE) mphase = 2;
      end
    end else begin
      if (!en) begin
        mphase = 0; blk_a.delete(); blk_b.delete();
      end else if (int'(dec) != mdec_prev) begin
        blk_a.delete(); blk_b.delete();
      end else begin
        blk_a.push_back(sa); blk_b.push_back(sb);
        n = 1 << eff_exp(int'(dec));
        if (blk_a.size() == n) begin
          suma = 0; sumb = 0;
          foreach (blk_a[i]) suma += blk_a[i];
          foreach (blk_b[i]) sumb += blk_b[i];
          e_dat_a = 14'(fdiv(suma, n));
          e_dat_b = 14'(fdiv(sumb, n));
          e_valid = 1'b1;
          blk_a.delete(); blk_b.delete();
        end
      end
    end
    mdec_prev = int'(dec);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dat_a"}, 32'(dat_a_o), 32'(e_dat_a));
    chk({tag, ".dat_b"}, 32'(dat_b_o), 32'(e_dat_b));
    chk({tag, ".valid"}, 32'(valid_o), 32'(e_valid));
    chk({tag, ".ovr_a"}, 32'(ovr_a_o), 32'(e_ovr_a));
    chk({tag, ".ovr_b"}, 32'(ovr_b_o), 32'(e_ovr_b));
    chk({tag, ".running"}, 32'(running_o), 32'(mphase == 2));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    hist_a.push_back(int'(pad_a)); hist_b.push_back(int'(pad_b));
    if (hist_a.size() > 3) begin void'(hist_a.pop_front()); void'(hist_b.pop_front()); end
    if (rst_n) model_edge(); else model_reset();
    #1;
    chk_all(tag);
  endtask

  function automatic logic [ADC_W-1:0] mid_rand();
    return 14'($urandom_range(16, 16367));
  endfunction

  initial begin
    int pulses;
    model_reset();
    #1;
    chk_all("reset0");
    for (int i = 0; i < 3; i++) step("in_reset");
    rst_n = 1'b1;
    step("idle"); step("idle");

    // Enable with full-scale pads during SETTLE: no flags, no valid.
    en = 1'b1; pad_a = 14'h0000; pad_b = 14'h3FFF;
    for (int i = 0; i < 14; i++) begin
      step("settle_fs");
      if (i == 0) begin pad_a = 14'h0000; pad_b = 14'h3FFF; end
    end
    chk("settle_no_ovr_a", 32'(ovr_a_o), 32'd0);
    chk("settle_not_running", 32'(running_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      pad_a = mid_rand(); pad_b = mid_rand();
      step("settle_to_run");
    end
    chk("run_entered", 32'(running_o), 32'd1);

    // Conversion, e=0
    pad_a = 14'h1FFF; step("conv");
    pad_a = 14'h2000; step("conv");
    pad_a = 14'h0000; step("conv");
    chk("conv_1fff", 32'(dat_a_o), 32'h0000);
    pad_a = 14'h3FFF; step("conv");
    chk("conv_2000", 32'(dat_a_o), 32'h3FFF);
    pad_a = mid_rand(); step("conv");
    chk("conv_0000", 32'(dat_a_o), 32'h1FFF);
    chk("ovr_a_set", 32'(ovr_a_o), 32'd1);
    pad_a = mid_rand(); step("conv");
    chk("conv_3fff", 32'(dat_a_o), 32'h2000);
    chk("valid_e0", 32'(valid_o), 32'd1);
    clr = 1'b1; pad_a = mid_rand(); step("clr_a");
    clr = 1'b0;
    chk("ovr_a_cleared", 32'(ovr_a_o), 32'd0);

    // Set and clear on the same edge for channel B
    pad_b = 14'h0000; step("ovrb");
    pad_b = mid_rand(); step("ovrb");
    clr = 1'b1; pad_b = mid_rand(); step("ovrb_set_clr");
    chk("ovr_b_set_wins", 32'(ovr_b_o), 32'd1);
    step("ovrb_clr");
    chk("ovr_b_clr_alone", 32'(ovr_b_o), 32'd0);
    clr = 1'b0;

    // Decimation by 4: 4,5,6,8 -> 5 and -1,-1,-1,-2 -> -2
    pad_a = 14'(raw_of(4)); step("dec2");
    dec = 4'd2; pad_a = 14'(raw_of(5)); step("dec2");
    pad_a = 14'(raw_of(6)); step("dec2");
    pad_a = 14'(raw_of(8)); step("dec2");
    pad_a = 14'(raw_of(-1)); step("dec2");
    pad_a = 14'(raw_of(-1)); step("dec2");
    chk("avg_pos", 32'(dat_a_o), 32'd5);
    chk("avg_pos_valid", 32'(valid_o), 32'd1);
    pad_a = 14'(raw_of(-1)); step("dec2");
    pad_a = 14'(raw_of(-2)); step("dec2");
    pad_a = mid_rand(); step("dec2");
    pad_a = mid_rand(); step("dec2");
    chk("avg_floor_neg", 32'(dat_a_o), 32'h3FFE);

    // Exponent change 2 -> 1 mid-block
    for (int i = 0; i < 3; i++) begin pad_a = mid_rand(); pad_b = mid_rand(); step("pre_change"); end
    dec = 4'd1;
    for (int i = 0; i < 8; i++) begin pad_a = mid_rand(); pad_b = mid_rand(); step("post_change"); end

    // Random mix of pads, exponents and clears while running
    for (int i = 0; i < 60; i++) begin
      pad_a = 14'($urandom_range(0, 16383));
      pad_b = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 9) == 0) dec = 4'($urandom_range(0, 3));
      clr = ($urandom_range(0, 7) == 0);
      step("random");
    end
    clr = 1'b0;

    // Clamped exponent 15 -> 10
    dec = 4'd15; pulses = 0;
    for (int i = 0; i < 2100; i++) begin
      pad_a = mid_rand(); pad_b = mid_rand();
      step("dec15");
      if (valid_o) pulses++;
    end
    chk("dec15_pulses", 32'(pulses), 32'd2);

    // Enable drop mid-block, then clear in IDLE
    dec = 4'd2; pad_b = mid_rand(); step("drop");
    pad_b = 14'h3FFF; step("drop");
    pad_b = mid_rand(); step("drop");
    step("drop");
    en = 1'b0; step("drop_edge");
    chk("drop_running", 32'(running_o), 32'd0);
    chk("drop_no_valid", 32'(valid_o), 32'd0);
    chk("drop_ovr_b_kept", 32'(ovr_b_o), 32'd1);
    for (int i = 0; i < 3; i++) step("idle2");
    clr = 1'b1; step("idle_clr");
    clr = 1'b0;
    chk("idle_clr_b", 32'(ovr_b_o), 32'd0);

    // Async reset in RUN, dec=3, mid-block
    dec = 4'd3; en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      pad_a = (i >= 18) ? 14'h0000 : mid_rand(); pad_b = mid_rand();
      step("pre_rst");
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_dat_a", 32'(dat_a_o), 32'd0);
    chk("arst_dat_b", 32'(dat_b_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_ovr_a", 32'(ovr_a_o), 32'd0);
    chk("arst_ovr_b", 32'(ovr_b_o), 32'd0);
    chk("arst_running", 32'(running_o), 32'd0);
    step("rst_hold"); step("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pad_a = mid_rand(); pad_b = mid_rand();
      step("post_rst");
    end
    chk("post_rst_running", 32'(running_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
